console_cmd_rx: RTL and testbench
=================================

// Module: console_cmd_rx
// PURPOSE
//  Command-frame receiver and initiator side of the console fs_read/fd_read handshake.
//  Parses host bytes from the UART/USB byte stream into a 2-bit com_state plus a config argument.
//  Presents them to the console core with fs_read, holding fs_read until fd_read acknowledges.
//  Sits between the host byte receiver and the console core.
// PARAMETERS
//  GAP_CYC   default 16'd50000  max clk cycles between bytes of one frame; exceeded -> resync
//  TMO_CYC   default 16'd60000  max clk cycles waiting on fd_read edge per handshake phase
//  HEAD0     default 8'h55      first frame header byte
//  HEAD1     default 8'hAA      second frame header byte
// PORTS
//  clk        in   1  system clock
//  rst        in   1  reset, asynchronous, active-high
//  rx_data    in   8  received byte
//  rx_vld     in   1  1-cycle strobe, rx_data valid
//  fs_read    out  1  command present to console core
//  fd_read    in   1  console core acknowledge
//  com_state  out  2  00 IDLE, 01 CONF, 10 READ, 11 SAME; stable between commands
//  conf_data  out  8  argument byte of last accepted command
//  err_chk    out  1  1-cycle pulse: checksum mismatch
//  err_cmd    out  1  1-cycle pulse: command byte > 8'h03
//  err_drop   out  1  1-cycle pulse: byte received while handshake busy
//  err_tmo    out  1  1-cycle pulse: handshake timeout
// BEHAVIOUR
//  - Clock and reset: already decided -- reset rst, asynchronous, active-high; clock clk.
//  - Reset values: state HUNT, fs_read 0, com_state 2'b00, conf_data 8'h00, all err_* 0, counters 0.
//  - Frame format: HEAD0 HEAD1 CMD ARG [CHK]; CHK = CMD ^ ARG.
//  - FSM states: HUNT, HDR1, CMD, ARG, CHK, ISSUE, RELEASE.
//    - HUNT: rx_vld & HEAD0 -> HDR1.
//    - HDR1: HEAD1 -> CMD; HEAD0 -> HDR1; any other byte -> HUNT.
//    - CMD: latch byte into cmd_r -> ARG.
//    - ARG: latch byte into arg_r -> CHK.
//    - CHK: on rx_vld, compare against cmd_r ^ arg_r.
//      - Mismatch: pulse err_chk, -> HUNT.
//      - Match with cmd_r > 3: pulse err_cmd, -> HUNT.
//      - Otherwise: same edge com_state <= cmd_r[1:0], conf_data <= arg_r, -> ISSUE.
//    - ISSUE: fs_read = 1 (decoded from state register; no glitch, same cycle as new com_state).
//      fd_read = 1 -> RELEASE.
//    - RELEASE: fs_read = 0; fd_read = 0 -> HUNT.
//  - Latency: fs_read rises the cycle after the rx_vld of the final frame byte.
//  - Gap timer: in HDR1/CMD/ARG/CHK, counts cycles since the last rx_vld.
//    Reaching GAP_CYC -> HUNT silently.
//  - Handshake timer: cleared on entry to ISSUE and on entry to RELEASE.
//    Reaching TMO_CYC in either state -> pulse err_tmo, fs_read 0, -> HUNT.
//    com_state and conf_data keep their new values.
//  - rx_vld in ISSUE/RELEASE: byte discarded, err_drop pulses for that cycle, no state change.
//    No frame buffering.
//  - com_state/conf_data change only at a CHK->ISSUE transition; the console samples them continuously.
//  - fd_read high already on entry to ISSUE: RELEASE next cycle, i.e. fs_read is high 1 cycle minimum.
//  - Reset mid-frame or mid-handshake: immediate return to reset values; partial frame lost.
// CONFIGURATION
//  CMD_CHKSUM_EN
//  - Defined: 5-byte frame, CHK state and err_chk as above.
//  - Undefined: 4-byte frame; the ARG byte goes directly to the cmd-range check and ISSUE;
//    CHK state is absent and err_chk is tied 0.
// STRUCTURE
//  Shared package console_pkg:
//  - COM_STATE_IDLE/CONF/READ/SAME codes.
//  - Default HEAD0/HEAD1 values.
//  - Command codes 8'h00..8'h03.
//  One sub-module, cmd_tmo_cnt: 16-bit clear/enable counter with a terminal flag at a
//  parameterised limit. Two instances: gap and handshake.
// TESTING
//  1. Frame 55 AA 02 07 05 (chksum on); fd_read=1 two cycles after fs_read rises
//     -> com_state=2'b10, conf_data=8'h07 in the fs_read-rise cycle; fs_read high exactly 2 cycles.
//  2. Frame 55 AA 01 10 00 -> err_chk 1 pulse; fs_read stays 0; com_state unchanged.
//  3. Frame 55 AA 05 00 05 -> err_cmd 1 pulse; no fs_read.
//  4. fd_read held 0 for TMO_CYC cycles after fs_read -> err_tmo pulse; fs_read 0; com_state keeps new value.
//  5. Bytes 55 AA 03, then idle GAP_CYC cycles, then 55 AA 00 00 00 -> first frame ignored;
//     second issues com_state=2'b00.
//  6. Byte during ISSUE -> err_drop pulse, handshake completes normally.
//     Then assert rst mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/console_pkg.sv
// Shared definitions for the console command receiver: com_state codes,
// command codes, default frame header bytes and the receiver state type.
package console_pkg;

    typedef enum logic [1:0] {
        COM_STATE_IDLE = 2'b00,
        COM_STATE_CONF = 2'b01,
        COM_STATE_READ = 2'b10,
        COM_STATE_SAME = 2'b11
    } com_state_t;

    typedef enum logic [7:0] {
        CMD_IDLE = 8'h00,
        CMD_CONF = 8'h01,
        CMD_READ = 8'h02,
        CMD_SAME = 8'h03
    } cmd_code_t;

    localparam logic [7:0] HEAD0_DEFAULT = 8'h55;
    localparam logic [7:0] HEAD1_DEFAULT = 8'hAA;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_HDR1,
        ST_CMD,
        ST_ARG,
        ST_CHK,
        ST_ISSUE,
        ST_RELEASE
    } rx_state_t;

    // Only codes 00..03 map onto a com_state.
    function automatic logic cmd_in_range(input logic [7:0] code);
        return (code <= CMD_SAME);
    endfunction

endpackage

// File: rtl/cmd_tmo_cnt.sv
// 16-bit clear/enable up-counter with a terminal flag at LIMIT.
// The count saturates at LIMIT so the flag holds until the next clear.
module cmd_tmo_cnt #(
    parameter logic [15:0] LIMIT = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [15:0] cnt;

    assign done = (cnt == LIMIT);

    // Count enabled cycles since the last clear, stopping at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 16'd0;
        end else if (clr) begin
            cnt <= 16'd0;
        end else if (en && !done) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/console_cmd_rx.sv
// Console command-frame receiver and fs_read/fd_read handshake initiator.
// Frame: HEAD0 HEAD1 CMD ARG [CHK], CHK = CMD ^ ARG.
// Build option CMD_CHKSUM_EN: when defined the frame carries the CHK byte and
// err_chk is live; otherwise the frame is 4 bytes and err_chk is tied low.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   HUNT    | waiting for HEAD0
//   HDR1    | HEAD0 seen, expecting HEAD1 (a repeated HEAD0 stays here)
//   CMD     | next byte is the command
//   ARG     | next byte is the argument
//   CHK     | next byte is the checksum (checksum build only)
//   ISSUE   | fs_read high, waiting for fd_read to rise
//   RELEASE | fs_read low, waiting for fd_read to fall
//
// On a handshake timeout fs_read has been high for TMO_CYC+1 cycles: the
// counter reaches the limit during the last ISSUE cycle.
module console_cmd_rx
    import console_pkg::*;
#(
    parameter logic [15:0] GAP_CYC = 16'd50000,
    parameter logic [15:0] TMO_CYC = 16'd60000,
    parameter logic [7:0]  HEAD0   = HEAD0_DEFAULT,
    parameter logic [7:0]  HEAD1   = HEAD1_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_vld,
    output logic       fs_read,
    input  logic       fd_read,
    output logic [1:0] com_state,
    output logic [7:0] conf_data,
    output logic       err_chk,
    output logic       err_cmd,
    output logic       err_drop,
    output logic       err_tmo
);

    rx_state_t  state_q, state_d, parse_st;
    logic [7:0] cmd_r;
    logic [7:0] arg_cur;
    logic       cmd_ld, issue, err_cmd_d, err_tmo_d;
    logic       busy, gap_done, hs_done, gap_clr, hs_clr;
`ifdef CMD_CHKSUM_EN
    logic [7:0] arg_r;
    logic       arg_ld, err_chk_d, err_chk_r;
`endif

    assign busy     = (state_q == ST_ISSUE) || (state_q == ST_RELEASE);
    assign fs_read  = (state_q == ST_ISSUE);
    assign err_drop = rx_vld && busy;
    assign gap_clr  = rx_vld || busy || (state_q == ST_HUNT);
    assign hs_clr   = !busy || (state_d != state_q);

`ifdef CMD_CHKSUM_EN
    assign arg_cur = arg_r;
    assign err_chk = err_chk_r;
`else
    assign arg_cur = rx_data;
    assign err_chk = 1'b0;
`endif

    cmd_tmo_cnt #(.LIMIT(GAP_CYC)) u_gap_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (gap_clr),
        .en   (1'b1),
        .done (gap_done)
    );

    cmd_tmo_cnt #(.LIMIT(TMO_CYC)) u_hs_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (hs_clr),
        .en   (busy),
        .done (hs_done)
    );

    // Next-state decode: handshake phases first, otherwise byte parsing with
    // an expired inter-byte gap treated as a return to HUNT before this byte.
    always_comb begin
        state_d   = state_q;
        parse_st  = state_q;
        cmd_ld    = 1'b0;
        issue     = 1'b0;
        err_cmd_d = 1'b0;
        err_tmo_d = 1'b0;
`ifdef CMD_CHKSUM_EN
        arg_ld    = 1'b0;
        err_chk_d = 1'b0;
`endif
        if (busy) begin
            if (hs_done) begin
                state_d   = ST_HUNT;
                err_tmo_d = 1'b1;
            end else if ((state_q == ST_ISSUE) && fd_read) begin
                state_d = ST_RELEASE;
            end else if ((state_q == ST_RELEASE) && !fd_read) begin
                state_d = ST_HUNT;
            end
        end else begin
            if (gap_done) begin
                parse_st = ST_HUNT;
            end
            state_d = parse_st;
            if (rx_vld) begin
                case (parse_st)
                    ST_HUNT: begin
                        if (rx_data == HEAD0) state_d = ST_HDR1;
                    end
                    ST_HDR1: begin
                        if (rx_data == HEAD1)      state_d = ST_CMD;
                        else if (rx_data != HEAD0) state_d = ST_HUNT;
                    end
                    ST_CMD: begin
                        cmd_ld  = 1'b1;
                        state_d = ST_ARG;
                    end
`ifdef CMD_CHKSUM_EN
                    ST_ARG: begin
                        arg_ld  = 1'b1;
                        state_d = ST_CHK;
                    end
                    ST_CHK: begin
                        state_d = ST_HUNT;
                        if (rx_data != (cmd_r ^ arg_r)) begin
                            err_chk_d = 1'b1;
                        end else if (!cmd_in_range(cmd_r)) begin
                            err_cmd_d = 1'b1;
                        end else begin
                            issue   = 1'b1;
                            state_d = ST_ISSUE;
                        end
                    end
`else
                    ST_ARG: begin
                        state_d = ST_HUNT;
                        if (!cmd_in_range(cmd_r)) begin
                            err_cmd_d = 1'b1;
                        end else begin
                            issue   = 1'b1;
                            state_d = ST_ISSUE;
                        end
                    end
`endif
                    default: state_d = ST_HUNT;
                endcase
            end
        end
    end

    // State, latched frame fields, presented command and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_HUNT;
            cmd_r     <= 8'h00;
            com_state <= COM_STATE_IDLE;
            conf_data <= 8'h00;
            err_cmd   <= 1'b0;
            err_tmo   <= 1'b0;
`ifdef CMD_CHKSUM_EN
            arg_r     <= 8'h00;
            err_chk_r <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            err_cmd <= err_cmd_d;
            err_tmo <= err_tmo_d;
            if (cmd_ld) cmd_r <= rx_data;
            if (issue) begin
                com_state <= cmd_r[1:0];
                conf_data <= arg_cur;
            end
`ifdef CMD_CHKSUM_EN
            err_chk_r <= err_chk_d;
            if (arg_ld) arg_r <= rx_data;
`endif
        end
    end

endmodule

// File: tb/tb_console_cmd_rx.sv
// Bench for console_cmd_rx: byte-buffer reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_console_cmd_rx;

    localparam logic [15:0] GAP = 16'd40;
    localparam logic [15:0] TMO = 16'd60;
`ifdef CMD_CHKSUM_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_vld = 1'b0;
    logic       fd_read = 1'b0;
    logic       fs_read, err_chk, err_cmd, err_drop, err_tmo;
    logic [1:0] com_state;
    logic [7:0] conf_data;

    always #5 clk = ~clk;

    console_cmd_rx #(
        .GAP_CYC(GAP), .TMO_CYC(TMO), .HEAD0(8'h55), .HEAD1(8'hAA)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld),
        .fs_read(fs_read), .fd_read(fd_read), .com_state(com_state),
        .conf_data(conf_data), .err_chk(err_chk), .err_cmd(err_cmd),
        .err_drop(err_drop), .err_tmo(err_tmo)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_buf holds the bytes of the frame being assembled; m_hs is the
    // handshake phase (0 none, 1 awaiting ack rise, 2 awaiting ack fall).
    logic [7:0] m_buf[$];
    int         m_idle = 0;
    int         m_hs = 0;
    int         m_hs_cnt = 0;
    logic [1:0] m_com = 2'b00;
    logic [7:0] m_conf = 8'h00;
    bit         m_echk = 0, m_ecmd = 0, m_etmo = 0;

    task automatic model_frame_done();
        logic [7:0] c, a;
        c = m_buf[2];
        a = m_buf[3];
`ifdef CMD_CHKSUM_EN
        if (m_buf[4] != (c ^ a)) begin
            m_echk = 1;
            return;
        end
`endif
        if (c > 8'd3) begin
            m_ecmd = 1;
        end else begin
            m_com    = c[1:0];
            m_conf   = a;
            m_hs     = 1;
            m_hs_cnt = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] d);
        if (m_buf.size() == 0) begin
            if (d == 8'h55) m_buf.push_back(d);
        end else if (m_buf.size() == 1) begin
            if (d == 8'hAA) m_buf.push_back(d);
            else if (d != 8'h55) m_buf.delete();
        end else begin
            m_buf.push_back(d);
            if (m_buf.size() == FL) begin
                model_frame_done();
                m_buf.delete();
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_buf.delete();
            m_idle = 0; m_hs = 0; m_hs_cnt = 0;
            m_com = 2'b00; m_conf = 8'h00;
            m_echk = 0; m_ecmd = 0; m_etmo = 0;
        end else begin
            m_echk = 0; m_ecmd = 0; m_etmo = 0;
            if (m_hs == 1) begin
                if (m_hs_cnt == int'(TMO)) begin m_etmo = 1; m_hs = 0; end
                else if (fd_read) begin m_hs = 2; m_hs_cnt = 0; end
                else m_hs_cnt++;
            end else if (m_hs == 2) begin
                if (m_hs_cnt == int'(TMO)) begin m_etmo = 1; m_hs = 0; end
                else if (!fd_read) m_hs = 0;
                else m_hs_cnt++;
            end else begin
                if (m_buf.size() > 0 && m_idle >= int'(GAP)) begin
                    m_buf.delete();
                    m_idle = 0;
                end
                if (rx_vld) begin
                    m_idle = 0;
                    model_byte(rx_data);
                end else if (m_buf.size() > 0) begin
                    m_idle++;
                end
            end
        end
    end

    // ---------------- per-cycle compare and statistics ----------------
    int         rises = 0, run = 0, last_len = 0;
    int         n_echk = 0, n_ecmd = 0, n_edrop = 0, n_etmo = 0;
    logic [1:0] rise_com = 2'b00;
    logic [7:0] rise_conf = 8'h00;
    logic       fs_prev = 1'b0;

    always @(negedge clk) begin
        check("fs_read",   fs_read,   (m_hs == 1));
        check("com_state", com_state, m_com);
        check("conf_data", conf_data, m_conf);
        check("err_chk",   err_chk,   m_echk);
        check("err_cmd",   err_cmd,   m_ecmd);
        check("err_tmo",   err_tmo,   m_etmo);
        check("err_drop",  err_drop,  (rx_vld && m_hs != 0));
        if (fs_read && !fs_prev) begin
            rises++;
            rise_com  = com_state;
            rise_conf = conf_data;
        end
        if (fs_read) run++;
        else if (fs_prev) begin last_len = run; run = 0; end
        if (err_chk)  n_echk++;
        if (err_cmd)  n_ecmd++;
        if (err_drop) n_edrop++;
        if (err_tmo)  n_etmo++;
        fs_prev = fs_read;
    end

    // ---------------- console responder ----------------
    int ack_delay = 2;   // cycles of fs_read before acking; 0 = never ack
    int rel_delay = 1;   // extra cycles fd_read stays high after fs_read drops

    initial begin : responder
        int hi, lo;
        hi = 0; lo = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                fd_read = 1'b0; hi = 0; lo = 0;
            end else begin
                if (fs_read) begin
                    hi++;
                    if (ack_delay > 0 && hi >= ack_delay) fd_read = 1'b1;
                end else hi = 0;
                if (fd_read && !fs_read) begin
                    lo++;
                    if (lo > rel_delay) fd_read = 1'b0;
                end else lo = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_vld = 1'b1; rx_data = b;
        tick();
        rx_vld = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
        send(8'h55); send(8'hAA); send(c); send(a);
`ifdef CMD_CHKSUM_EN
        send(k);
`else
        if (k == 8'hFF) rx_data = 8'h00;   // checksum byte not sent in this build
`endif
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench time limit");
    end

    initial begin : main
        int s_rise, s_chk, s_cmd, s_drop, s_tmo, kind, g, nb;
        logic [7:0] c, a, k;
        logic [7:0] bytes[$];

        #1 rst = 1'b1;
        tick(); tick();
        check("rst_fs_read", fs_read, 0);
        check("rst_com", com_state, 0);
        check("rst_conf", conf_data, 0);
        rst = 1'b0;
        tick();

        // 1: valid READ command, ack on second fs_read cycle
        ack_delay = 2; rel_delay = 1;
        s_rise = rises;
        send_frame(8'h02, 8'h07, 8'h05);
        idle(15);
        check("t1_rises", rises - s_rise, 1);
        check("t1_com", rise_com, 2'b10);
        check("t1_conf", rise_conf, 8'h07);
        check("t1_fs_len", last_len, 2);

`ifdef CMD_CHKSUM_EN
        // 2: checksum mismatch
        s_rise = rises; s_chk = n_echk;
        send_frame(8'h01, 8'h10, 8'h00);
        idle(10);
        check("t2_err_chk", n_echk - s_chk, 1);
        check("t2_rises", rises - s_rise, 0);
        check("t2_com", com_state, 2'b10);
`endif

        // 3: command out of range
        s_rise = rises; s_cmd = n_ecmd;
        send_frame(8'h05, 8'h00, 8'h05);
        idle(10);
        check("t3_err_cmd", n_ecmd - s_cmd, 1);
        check("t3_rises", rises - s_rise, 0);

        // 4: no acknowledge -> handshake timeout
        ack_delay = 0;
        s_tmo = n_etmo;
        send_frame(8'h03, 8'h5A, 8'h59);
        idle(int'(TMO) + 20);
        check("t4_err_tmo", n_etmo - s_tmo, 1);
        check("t4_fs_len", last_len, int'(TMO) + 1);
        check("t4_fs_read", fs_read, 0);
        check("t4_com", com_state, 2'b11);
        check("t4_conf", conf_data, 8'h5A);
        ack_delay = 3;

        // gap one cycle short of the limit: frame still accepted
        s_rise = rises;
        send(8'h55); send(8'hAA); send(8'h01);
        idle(int'(GAP) - 1);
        send(8'h22);
`ifdef CMD_CHKSUM_EN
        send(8'h23);
`endif
        idle(15);
        check("gap_ok_rises", rises - s_rise, 1);
        check("gap_ok_com", rise_com, 2'b01);
        check("gap_ok_conf", rise_conf, 8'h22);

        // 5: gap reaches the limit -> partial frame dropped
        s_rise = rises;
        send(8'h55); send(8'hAA); send(8'h03);
        idle(int'(GAP));
        send_frame(8'h00, 8'h00, 8'h00);
        idle(15);
        check("t5_rises", rises - s_rise, 1);
        check("t5_com", rise_com, 2'b00);
        check("t5_conf", rise_conf, 8'h00);

        // 6: byte during ISSUE is dropped, handshake still completes
        ack_delay = 4; rel_delay = 1;
        s_rise = rises; s_drop = n_edrop;
        send_frame(8'h01, 8'h33, 8'h32);
        send(8'h55);
        idle(15);
        check("t6_err_drop", n_edrop - s_drop, 1);
        check("t6_rises", rises - s_rise, 1);
        check("t6_fs_len", last_len, 4);
        check("t6_com", com_state, 2'b01);
        check("t6_conf", conf_data, 8'h33);

        // reset mid-frame
        send(8'h55); send(8'hAA); send(8'h02);
        #3 rst = 1'b1;
        #1;
        check("rst_mid_fs", fs_read, 0);
        check("rst_mid_com", com_state, 0);
        check("rst_mid_conf", conf_data, 0);
        check("rst_mid_errs", {err_chk, err_cmd, err_drop, err_tmo}, 0);
        tick();
        rst = 1'b0;
        ack_delay = 2;
        s_rise = rises;
        send_frame(8'h03, 8'h44, 8'h47);
        idle(15);
        check("post_rst_rises", rises - s_rise, 1);
        check("post_rst_com", rise_com, 2'b11);

        // randomized traffic, checked cycle by cycle against the model
        for (int it = 0; it < 200; it++) begin
            ack_delay = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            rel_delay = ($urandom_range(0, 11) == 0) ? int'(TMO) + 5 : $urandom_range(0, 3);
            kind = $urandom_range(0, 9);
            c = 8'($urandom_range(0, 3));
            a = 8'($urandom);
            if (kind == 1) c = 8'($urandom_range(4, 255));
            k = c ^ a;
            if (kind == 2) k = ~k;
            bytes.delete();
            bytes.push_back(8'h55); bytes.push_back(8'hAA);
            bytes.push_back(c); bytes.push_back(a);
`ifdef CMD_CHKSUM_EN
            bytes.push_back(k);
`endif
            if (kind == 0) begin
                bytes.delete();
                nb = $urandom_range(1, 4);
                for (int j = 0; j < nb; j++)
                    bytes.push_back(($urandom_range(0, 2) == 0) ? 8'h55 : 8'($urandom));
            end
            if (kind == 3) bytes.push_front(8'($urandom));
            foreach (bytes[j]) begin
                g = ($urandom_range(0, 29) == 0) ? int'(GAP) - 1 + $urandom_range(0, 2)
                                                  : $urandom_range(0, 3);
                idle(g);
                send(bytes[j]);
            end
            idle($urandom_range(0, 10));
        end
        ack_delay = 2; rel_delay = 1;
        idle(2 * int'(TMO) + 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
